// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared key codes and row-pattern helpers for the keypad scanner
//
// Key codes use the {row[1:0], col[1:0]} encoding emitted by keypad_scanner.
// Layout: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = * 0 # D.
// Helpers decode an active-low row pattern with exactly one row pulled low.
package keypad_scanner_pkg;

    localparam logic [3:0] KEY_1    = 4'b0000;
    localparam logic [3:0] KEY_2    = 4'b0001;
    localparam logic [3:0] KEY_3    = 4'b0010;
    localparam logic [3:0] KEY_A    = 4'b0011;
    localparam logic [3:0] KEY_4    = 4'b0100;
    localparam logic [3:0] KEY_5    = 4'b0101;
    localparam logic [3:0] KEY_6    = 4'b0110;
    localparam logic [3:0] KEY_B    = 4'b0111;
    localparam logic [3:0] KEY_7    = 4'b1000;
    localparam logic [3:0] KEY_8    = 4'b1001;
    localparam logic [3:0] KEY_9    = 4'b1010;
    localparam logic [3:0] KEY_C    = 4'b1011;
    localparam logic [3:0] KEY_ASS  = 4'b1100;
    localparam logic [3:0] KEY_0    = 4'b1101;
    localparam logic [3:0] KEY_HASH = 4'b1110;
    localparam logic [3:0] KEY_D    = 4'b1111;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // True when exactly one row is pulled low.
    function automatic logic rows_single_low(input logic [3:0] rows);
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: rows_single_low = 1'b1;
            default:                             rows_single_low = 1'b0;
        endcase
    endfunction

    // Index of the low row; only meaningful when rows_single_low() is true.
    function automatic logic [1:0] rows_low_index(input logic [3:0] rows);
        case (rows)
            4'b1101: rows_low_index = 2'd1;
            4'b1011: rows_low_index = 2'd2;
            4'b0111: rows_low_index = 2'd3;
            default: rows_low_index = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// rtl/keypad_scanner_sync_2ff.sv - reusable two-flop synchronizer (module sync_2ff)
//
// Ports:
//   clk       in   system clock
//   reset_in  in   synchronous active-high reset, loads RESET_VAL into both stages
//   d         in   WIDTH  asynchronous input
//   q         out  WIDTH  synchronized output, two clk cycles behind d
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and one-pulse-per-press encoding
//
// Ports:
//   clk        in   system clock
//   reset_in   in   synchronous active-high reset
//   row_in     in   4  keypad rows, active-low, asynchronous to clk
//   col_out    out  4  column drive, active column low
//   key_code   out  4  {row,col} of the last accepted key, held until the next accept
//   data_ready out  1  one-cycle pulse, key_code valid in the same cycle
//
// Optional macro KEYPAD_REPEAT_EN adds auto-repeat while a key stays held:
// first extra pulse REPEAT_DELAY cycles after the original, then every REPEAT_PERIOD.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       data_ready
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] DIV_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("keypad_scanner: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_e;

    logic [3:0] rs;

    sync_2ff #(.WIDTH(4), .RESET_VAL(4'b1111)) u_row_sync (
        .clk      (clk),
        .reset_in (reset_in),
        .d        (row_in),
        .q        (rs)
    );

    state_e        state_d, state_q;
    logic [1:0]    col_idx_d, col_idx_q;
    logic [SW-1:0] div_d, div_q;
    logic [DW-1:0] cnt_d, cnt_q;
    logic [1:0]    cand_row_d, cand_row_q;
    logic [3:0]    col_out_d, col_out_q;
    logic [3:0]    key_code_d, key_code_q;
    logic          data_ready_d, data_ready_q;
    logic [3:0]    cand_rows;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [RW-1:0] REP_FIRST_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

    // Counts cycles since the last pulse while in HELD; frozen in RELEASE so
    // release bounce does not restart the repeat cadence.
    logic [RW-1:0] rep_cnt_d, rep_cnt_q;
    logic          rep_first_d, rep_first_q;
`endif

    // Row pattern the candidate key must keep producing on the held column.
    assign cand_rows = ~(4'b0001 << cand_row_q);

    always_comb begin
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        div_d        = div_q;
        cnt_d        = cnt_q;
        cand_row_d   = cand_row_q;
        key_code_d   = key_code_q;
        data_ready_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d    = rep_cnt_q;
        rep_first_d  = rep_first_q;
`endif
        case (state_q)
            ST_SCAN: begin
                // Rows are sampled only on the last divider count so they
                // have settled after the column change.
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (rows_single_low(rs)) begin
                        cand_row_d = rows_low_index(rs);
                        cnt_d      = '0;
                        state_d    = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (rs == cand_rows) begin
                    if (cnt_q == DB_LAST) begin
                        key_code_d   = {cand_row_q, col_idx_q};
                        data_ready_d = 1'b1;
                        cnt_d        = '0;
                        state_d      = ST_HELD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    div_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_HELD: begin
                if (rs == ROWS_IDLE) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rep_cnt_q == (rep_first_q ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
                    data_ready_d = 1'b1;
                    rep_cnt_d    = '0;
                    rep_first_d  = 1'b0;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                if (rs == ROWS_IDLE) begin
                    if (cnt_q == DB_LAST) begin
                        cnt_d     = '0;
                        div_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = ST_SCAN;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = ST_HELD;
                end
            end
            default: state_d = ST_SCAN;
        endcase
        col_out_d = ~(4'b0001 << col_idx_d);
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q      <= ST_SCAN;
            col_idx_q    <= '0;
            div_q        <= '0;
            cnt_q        <= '0;
            cand_row_q   <= '0;
            col_out_q    <= 4'b1110;
            key_code_q   <= '0;
            data_ready_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q    <= '0;
            rep_first_q  <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            col_idx_q    <= col_idx_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            cand_row_q   <= cand_row_d;
            col_out_q    <= col_out_d;
            key_code_q   <= key_code_d;
            data_ready_q <= data_ready_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q    <= rep_cnt_d;
            rep_first_q  <= rep_first_d;
`endif
        end
    end

    assign col_out    = col_out_q;
    assign key_code   = key_code_q;
    assign data_ready = data_ready_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int REPEAT_DELAY    = 40;
    localparam int REPEAT_PERIOD   = 10;

    logic       clk = 1'b0;
    logic       reset_in = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       data_ready;

    // Pressed keys, bit index row*4 + col.
    logic [15:0] keys = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [3:0] exp_q[$];
    int         pulse_cyc[$];
    logic       rst_edge = 1'b1;
    logic [3:0] prev_key = 4'b0000;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_code   (key_code),
        .data_ready (data_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= reset_in;
    end

    // A pressed key shorts its row to the driven-low column.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pulse pops the scoreboard; key_code may only move with a pulse.
    always @(negedge clk) begin
        if (!rst_edge && key_code !== prev_key)
            check("key_code_moves_only_with_pulse", {31'd0, data_ready}, 32'd1);
        prev_key = key_code;
        if (data_ready === 1'b1) begin
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: key_code=%b, expected no pulse", key_code);
            end else begin
                check("pulse_key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] val, input string name);
        int n;
        n = 0;
        while (col_out !== val && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (col_out !== val) check(name, {28'd0, col_out}, {28'd0, val});
    endtask

    task automatic wait_col_not(input logic [3:0] val, input string name);
        int n;
        n = 0;
        while (col_out === val && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (col_out === val) check(name, {28'd0, col_out}, {28'd0, ~val});
    endtask

    task automatic wait_pulse(input string name);
        int n;
        n = 0;
        while (data_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (data_ready !== 1'b1) check(name, {31'd0, data_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rot_seq [5];
        int         last_toggle;
        int         first;
        int         seen;
        logic [15:0] bounce_key;

        rot_seq[0] = 4'b1110; rot_seq[1] = 4'b1101; rot_seq[2] = 4'b1011;
        rot_seq[3] = 4'b0111; rot_seq[4] = 4'b1110;

        // Reset state
        reset_in = 1'b1;
        tick(3);
        check("reset_col_out", {28'd0, col_out}, 32'h0000000e);
        check("reset_key_code", {28'd0, key_code}, 32'd0);
        check("reset_data_ready", {31'd0, data_ready}, 32'd0);
        reset_in = 1'b0;
        tick(2);

        // 1: hold '5' (row1, col1) for 60 cycles
        pulse_cyc.delete();
        exp_q.push_back(4'b0101);
        keys = 16'h0020;
        tick(60);
        check("t1_pulse_count", pulse_cyc.size(), 32'd1);
        check("t1_key_code", {28'd0, key_code}, 32'h5);
        check("t1_col_held", {28'd0, col_out}, 32'hd);
        keys = '0;
        tick(5);
        check("t1_col_held_in_release", {28'd0, col_out}, 32'hd);
        tick(20);

        // 2: '#' (row3, col2) bounces every 3 cycles for 20 cycles, then steady
        pulse_cyc.delete();
        exp_q.push_back(4'b1110);
        last_toggle = 0;
        for (int i = 0; i < 20; i++) begin
            bounce_key = (((i / 3) % 2) == 0) ? 16'h4000 : 16'h0000;
            if (bounce_key != keys) last_toggle = cyc;
            keys = bounce_key;
            tick(1);
        end
        keys = 16'h4000;
        tick(30);
        check("t2_pulse_count", pulse_cyc.size(), 32'd1);
        check("t2_key_code", {28'd0, key_code}, 32'he);
        if (pulse_cyc.size() > 0)
            check("t2_stable_before_pulse", {31'd0, (pulse_cyc[0] - last_toggle) >= DEBOUNCE_CYCLES}, 32'd1);
        keys = '0;
        tick(25);

        // 3: 5-cycle glitch on '1' (row0, col0), then column rotation
        pulse_cyc.delete();
        keys = 16'h0001;
        tick(5);
        keys = '0;
        tick(20);
        wait_col_not(4'b1110, "t3_rotation_leave_col0");
        wait_col(4'b1110, "t3_rotation_reach_col0");
        for (int k = 0; k < 5; k++) begin
            check("t3_rotation", {28'd0, col_out}, {28'd0, rot_seq[k]});
            tick(SCAN_DIV);
        end
        check("t3_no_pulse", pulse_cyc.size(), 32'd0);

        // 4: rows 0 and 1 both low in column 2
        pulse_cyc.delete();
        keys = 16'h0044;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < 4; c++)
                if (col_out === ~(4'b0001 << c)) seen = seen | (1 << c);
            tick(1);
        end
        check("t4_no_pulse", pulse_cyc.size(), 32'd0);
        check("t4_all_columns_scanned", seen, 32'hf);
        keys = '0;
        tick(10);

        // 5: reset for one cycle in the middle of debouncing '7' (row2, col0)
        pulse_cyc.delete();
        wait_col(4'b1101, "t5_wait_col1");
        keys = 16'h0100;
        wait_col(4'b1110, "t5_wait_col0");
        tick(6);
        reset_in = 1'b1;
        keys = '0;
        tick(1);
        check("t5_reset_col_out", {28'd0, col_out}, 32'he);
        check("t5_reset_key_code", {28'd0, key_code}, 32'd0);
        check("t5_reset_data_ready", {31'd0, data_ready}, 32'd0);
        reset_in = 1'b0;
        tick(30);
        check("t5_no_pulse", pulse_cyc.size(), 32'd0);

        // 6: hold 'A' (row0, col3) for 75 cycles after its first pulse
        pulse_cyc.delete();
        exp_q.push_back(4'b0011);
`ifdef KEYPAD_REPEAT_EN
        repeat (4) exp_q.push_back(4'b0011);
`endif
        keys = 16'h0008;
        wait_pulse("t6_first_pulse");
        tick(75);
        keys = '0;
        tick(30);
        check("t6_key_code", {28'd0, key_code}, 32'h3);
`ifdef KEYPAD_REPEAT_EN
        check("t6_pulse_count", pulse_cyc.size(), 32'd5);
        if (pulse_cyc.size() == 5) begin
            first = pulse_cyc[0];
            check("t6_repeat_1", pulse_cyc[1] - first, 32'd40);
            check("t6_repeat_2", pulse_cyc[2] - first, 32'd50);
            check("t6_repeat_3", pulse_cyc[3] - first, 32'd60);
            check("t6_repeat_4", pulse_cyc[4] - first, 32'd70);
        end
`else
        first = 0;
        check("t6_pulse_count", pulse_cyc.size(), 32'd1);
`endif

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
